// File: rtl/i2c_slave_rx_pkg.sv
// Shared definitions for the write-only I2C slave receiver.
// Holds the bus field widths, the R/W bit position, the default slave
// address and the receiver FSM state encoding.
package i2c_slave_rx_pkg;

    localparam int         I2C_ADDR_W       = 7;
    localparam int         I2C_BYTE_W       = 8;
    localparam int         I2C_RW_BIT       = 0;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h51;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ACK_ADDR  = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_ACK  = 3'd4,
        ST_WAIT_STOP = 3'd5
    } state_t;

endpackage

// File: rtl/i2c_slave_rx_line_sync.sv
// Synchronizer plus edge detector for one I2C line.
// Ports:
//   clk, reset   system clock, async active-low reset
//   line         raw bus line (SCL or SDL)
//   level        synchronized level, aligned with rise/fall
//   rise, fall   one-clk registered edge strobes of the synchronized line
// The chain resets to the idle-high bus level so releasing reset never
// produces a phantom edge.
module i2c_line_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            // synchronizer stages
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            // edge-detect stage
            prev_q <= synced;
            rise   <= synced & ~prev_q;
            fall   <= ~synced & prev_q;
        end
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver.
// Decodes START / address+R/W / data bytes / STOP from oversampled SCL and
// SDL, ACKs write transfers addressed to SLAVE_ADDR and hands each accepted
// byte to local logic.
// Ports:
//   clk        system clock (>= 8x SCL rate)
//   reset      async active-low reset
//   SCL        I2C clock, sampled only
//   SDL        I2C data, open-drain (driven 0 or released)
//   rx_ready   local sink can take a byte, sampled at the 8th data bit
//   data_out   last accepted byte, held until the next one
//   data_valid one-clk strobe, data_out just updated
//   addr_hit   one-clk strobe, own address with R/W=0 received
//   nack_ovr   one-clk strobe, data byte NACKed because rx_ready was low
//   busy       high from START to STOP
module i2c_slave_rx
    import i2c_slave_rx_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCL,
    inout  wire                   SDL,
    input  logic                  rx_ready,
    output logic [I2C_BYTE_W-1:0] data_out,
    output logic                  data_valid,
    output logic                  addr_hit,
    output logic                  nack_ovr,
    output logic                  busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .line  (SCL),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .line  (SDL),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    state_t                state,   state_n;
    logic [2:0]            cnt,     cnt_n;
    logic [I2C_BYTE_W-1:0] shift_q, shift_n;
    logic [I2C_BYTE_W-1:0] data_n;
    logic                  sda_low, sda_low_n;
    logic                  ack_q,   ack_n;
    logic                  phase_q, phase_n;   // 0: waiting for fall that opens ACK slot, 1: for fall that closes it
    logic                  busy_n, valid_n, hit_n, nack_n;

    logic                  start_det, stop_det;
    logic [I2C_BYTE_W-1:0] shifted;
    logic                  byte_end;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign shifted   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
    assign byte_end  = scl_rise & (cnt == 3'd7);

    assign SDL = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            shift_q    <= '0;
            data_out   <= '0;
            sda_low    <= 1'b0;
            ack_q      <= 1'b0;
            phase_q    <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            addr_hit   <= 1'b0;
            nack_ovr   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift_q    <= shift_n;
            data_out   <= data_n;
            sda_low    <= sda_low_n;
            ack_q      <= ack_n;
            phase_q    <= phase_n;
            busy       <= busy_n;
            data_valid <= valid_n;
            addr_hit   <= hit_n;
            nack_ovr   <= nack_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = shift_q;
        data_n    = data_out;
        sda_low_n = sda_low;
        ack_n     = ack_q;
        phase_n   = phase_q;
        busy_n    = busy;
        valid_n   = 1'b0;
        hit_n     = 1'b0;
        nack_n    = 1'b0;

        // START and STOP override everything, including a simultaneous SCL edge.
        if (start_det) begin
            state_n   = ST_ADDR;
            cnt_n     = 3'd0;
            sda_low_n = 1'b0;
            phase_n   = 1'b0;
            busy_n    = 1'b1;
        end else if (stop_det) begin
            state_n   = ST_IDLE;
            sda_low_n = 1'b0;
            phase_n   = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n = shifted;
                        cnt_n   = cnt + 3'd1;
                    end
                    if (byte_end) begin
                        if (shifted[I2C_BYTE_W-1:1] == SLAVE_ADDR && !shifted[I2C_RW_BIT]) begin
                            state_n = ST_ACK_ADDR;
                            hit_n   = 1'b1;
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_n   = 1'b1;
                            sda_low_n = 1'b1;
                        end else begin
                            phase_n   = 1'b0;
                            sda_low_n = 1'b0;
                            state_n   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_n = shifted;
                        cnt_n   = cnt + 3'd1;
                    end
                    if (byte_end) begin
                        state_n = ST_DATA_ACK;
                        if (rx_ready) begin
                            data_n  = shifted;
                            valid_n = 1'b1;
                            ack_n   = 1'b1;
                        end else begin
                            nack_n  = 1'b1;
                            ack_n   = 1'b0;
                        end
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_n   = 1'b1;
                            sda_low_n = ack_q;
                        end else begin
                            phase_n   = 1'b0;
                            sda_low_n = 1'b0;
                            state_n   = ack_q ? ST_DATA : ST_WAIT_STOP;
                        end
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_low_n = 1'b0;
                end
                default: begin
                    state_n   = ST_IDLE;
                    sda_low_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
`timescale 1ns/1ps
module tb_i2c_slave_rx;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       SCL      = 1'b1;
    logic       rx_ready = 1'b1;
    logic       m_low    = 1'b0;
    wire        SDL;
    logic [7:0] data_out;
    logic       data_valid, addr_hit, nack_ovr, busy;

    pullup (SDL);
    assign SDL = m_low ? 1'b0 : 1'bz;

    i2c_slave_rx #(.SLAVE_ADDR(7'h51), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .SCL        (SCL),
        .SDL        (SDL),
        .rx_ready   (rx_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr_hit   (addr_hit),
        .nack_ovr   (nack_ovr),
        .busy       (busy)
    );

    always #50 clk = ~clk;   // 10 MHz

    int n_checks = 0;
    int n_errors = 0;

    // transaction-level reference model
    bit         exp_busy  = 1'b0;
    logic [7:0] exp_dout  = 8'h00;
    bit         in_addr   = 1'b0;
    bit         accepting = 1'b0;
    bit         exp_ack   = 1'b0;
    int         hit_pend  = 0;
    int         nack_pend = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_byte  = 8'h00;
    bit         settled   = 1'b0;
    int         dv_count  = 0;
    int         hit_count = 0;
    int         nack_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_busy = 0; exp_dout = 8'h00; in_addr = 0; accepting = 0;
        exp_ack = 0; hit_pend = 0; nack_pend = 0; exp_q.delete();
    endtask

    task automatic model_start();
        exp_busy = 1; in_addr = 1; accepting = 0;
    endtask

    task automatic model_stop();
        exp_busy = 0; in_addr = 0; accepting = 0;
    endtask

    task automatic model_byte_done();
        if (in_addr) begin
            in_addr = 0;
            accepting = (cur_byte == {7'h51, 1'b0});
            exp_ack = accepting;
            if (accepting) hit_pend++;
        end else if (accepting) begin
            if (rx_ready) begin
                exp_dout = cur_byte;
                exp_q.push_back(cur_byte);
                exp_ack = 1;
            end else begin
                nack_pend++;
                accepting = 0;
                exp_ack = 0;
            end
        end else begin
            exp_ack = 0;
        end
    endtask

    // compare process
    always @(negedge clk) begin
        if (reset) begin
            if (data_valid + addr_hit + nack_ovr != 0)
                chk("pulses_per_clk", 32'(data_valid) + 32'(addr_hit) + 32'(nack_ovr), 1);
            if (data_valid) begin
                dv_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL data_valid_unexpected: got data_valid=1 data_out=%0h expected no pulse", data_out);
                end else begin
                    n_checks--;
                    chk("data_out_at_valid", data_out, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            if (addr_hit) begin
                hit_count++;
                n_checks++;
                if (hit_pend == 0) begin
                    n_errors++;
                    $display("FAIL addr_hit_unexpected: got addr_hit=1 expected 0");
                end else hit_pend--;
            end
            if (nack_ovr) begin
                nack_count++;
                n_checks++;
                if (nack_pend == 0) begin
                    n_errors++;
                    $display("FAIL nack_ovr_unexpected: got nack_ovr=1 expected 0");
                end else nack_pend--;
            end
            if (settled) begin
                chk("busy", busy, exp_busy);
                chk("data_out_hold", data_out, exp_dout);
            end
        end
    end

    // bus master; every segment is a multiple of 50 ns so line changes stay
    // 25 ns away from clock edges
    task automatic hold(input int t);
        settled = 0;
        #500;
        settled = 1;
        #(t - 500);
    endtask

    task automatic i2c_start();
        m_low = 0; hold(600);
        SCL = 1;   hold(650);
        m_low = 1; model_start(); hold(600);
        SCL = 0;   hold(650);
    endtask

    task automatic i2c_stop();
        m_low = 1; hold(600);
        SCL = 1;   hold(600);
        m_low = 0; model_stop(); hold(650);
    endtask

    task automatic send_bit(input bit b, input bit last);
        m_low = !b; hold(600);
        SCL = 1;
        if (last) model_byte_done();
        hold(600);
        if (b) chk("sdl_released_on_1", SDL, 1'b1);
        hold(650);
        SCL = 0;    hold(650);
    endtask

    task automatic send_byte(input logic [7:0] b);
        cur_byte = b;
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0);
    endtask

    task automatic ack_slot();
        m_low = 0; hold(600);
        SCL = 1;   hold(600);
        chk("ack_slot_sdl", SDL, exp_ack ? 1'b0 : 1'b1);
        hold(650);
        SCL = 0;   hold(650);
    endtask

    task automatic drain();
        #2000;
        chk("hit_drained", hit_pend, 0);
        chk("nack_drained", nack_pend, 0);
        chk("bytes_drained", exp_q.size(), 0);
    endtask

    initial begin
        #9_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, n0;
        logic [7:0] rb;
        int nb, k, mode;

        model_reset();
        #525;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sdl", SDL, 1'b1);
        #500;
        reset = 1;          // t = 1025
        #1000;

        // basic write A2 / A0
        d0 = dv_count; h0 = hit_count;
        i2c_start(); send_byte(8'hA2); ack_slot();
        send_byte(8'hA0); ack_slot(); i2c_stop(); drain();
        chk("t1_data_out", data_out, 8'hA0);
        chk("t1_hits", hit_count - h0, 1);
        chk("t1_valids", dv_count - d0, 1);

        // other address: never ACKed, data ignored
        d0 = dv_count; h0 = hit_count;
        i2c_start(); send_byte(8'hA4); ack_slot();
        send_byte(8'hFF); ack_slot(); i2c_stop(); drain();
        chk("t2_hits", hit_count - h0, 0);
        chk("t2_data_out", data_out, 8'hA0);

        // read request: NACK
        h0 = hit_count;
        i2c_start(); send_byte(8'hA3); ack_slot();
        send_byte(8'hFF); ack_slot(); i2c_stop(); drain();
        chk("t3_hits", hit_count - h0, 0);

        // overflow: rx_ready low
        n0 = nack_count; d0 = dv_count;
        i2c_start(); send_byte(8'hA2); ack_slot();
        rx_ready = 0; send_byte(8'h55); ack_slot();
        rx_ready = 1; send_byte(8'hFF); ack_slot(); i2c_stop(); drain();
        chk("t4_nacks", nack_count - n0, 1);
        chk("t4_valids", dv_count - d0, 0);
        chk("t4_data_out", data_out, 8'hA0);

        // partial byte then repeated START
        d0 = dv_count;
        i2c_start(); send_byte(8'hA2); ack_slot();
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        i2c_start(); send_byte(8'hA2); ack_slot();
        send_byte(8'h3C); ack_slot(); i2c_stop(); drain();
        chk("t5_data_out", data_out, 8'h3C);
        chk("t5_valids", dv_count - d0, 1);

        // reset while ACK is driven low
        i2c_start(); send_byte(8'hA2);
        m_low = 0; settled = 0;
        #600;
        SCL = 1;
        #300;
        chk("t6_ack_low", SDL, 1'b0);
        reset = 0;
        #1;
        chk("t6_sdl_released", SDL, 1'b1);
        chk("t6_data_out", data_out, 8'h00);
        chk("t6_busy", busy, 1'b0);
        chk("t6_pulses", {data_valid, addr_hit, nack_ovr}, 3'b000);
        model_reset();
        #299;
        reset = 1;
        hold(1000);
        i2c_start(); send_byte(8'hA2); ack_slot();
        send_byte(8'h5A); ack_slot(); i2c_stop(); drain();
        chk("t6_after_reset", data_out, 8'h5A);

        // randomized transactions
        for (int t = 0; t < 24; t++) begin
            rb = ($urandom_range(0, 3) != 0) ? 8'hA2 : 8'($urandom);
            nb = $urandom_range(0, 3);
            i2c_start(); send_byte(rb); ack_slot();
            for (int j = 0; j < nb; j++) begin
                rx_ready = ($urandom_range(0, 4) != 0);
                send_byte(8'($urandom)); ack_slot();
            end
            rx_ready = 1;
            mode = $urandom_range(0, 3);
            if (mode < 2) begin
                k = $urandom_range(1, 6);
                for (int i = 0; i < k; i++) send_bit(1'($urandom), 1'b0);
                if (mode == 0) begin
                    i2c_start(); send_byte(8'hA2); ack_slot();
                    send_byte(8'($urandom)); ack_slot();
                end
            end
            i2c_stop(); drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
